// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier and its product accumulator.
package booth_pkg;

   localparam int unsigned N_DEF = 4;

   typedef enum logic {ACCUM, EMIT} state_e;

   function automatic logic signed [63:0] sext_prod(input logic signed [2*N_DEF-1:0] p);
      return 64'(p);
   endfunction

   function automatic longint sat_max(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/booth_prod_accum_if.sv
// Product-in / block-sum-out handshake bundle for booth_prod_accum.
interface booth_prod_accum_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned LEN   = 8
);
   localparam int unsigned CNT_W = $clog2(LEN + 1);

   logic               clear;
   logic               prod_valid;
   logic               prod_ready;
   logic [2*N-1:0]     prod;
   logic               acc_valid;
   logic               acc_ready;
   logic [ACC_W-1:0]   acc_out;
   logic               out_sat;
   logic [CNT_W-1:0]   cnt;

   modport master (
      output clear, prod_valid, prod, acc_ready,
      input  prod_ready, acc_valid, acc_out, out_sat, cnt
   );

   modport slave (
      input  clear, prod_valid, prod, acc_ready,
      output prod_ready, acc_valid, acc_out, out_sat, cnt
   );
endinterface

// File: rtl/booth_sat_add.sv
// Combinational signed saturating add of a narrow product into a wide accumulator.
module booth_sat_add
   import booth_pkg::*;
#(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned ACC_W = 16
) (
   input  logic signed [IN_W-1:0]  prod,
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] sum,
   output logic                    ovf
);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

   logic signed [ACC_W:0] wide;

   assign wide = {{(ACC_W + 1 - IN_W){prod[IN_W-1]}}, prod} + {acc[ACC_W-1], acc};
   // Overflow when the two top bits of the one-bit-wider sum disagree.
   assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];
   assign sum  = ovf ? (wide[ACC_W] ? SAT_MIN : SAT_MAX) : wide[ACC_W-1:0];
endmodule

// File: rtl/booth_prod_accum.sv
// Sums blocks of LEN signed products with saturation and emits one result per block.
module booth_prod_accum
   import booth_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned LEN   = 8
) (
   input logic              clk,
   input logic              rst,
   booth_prod_accum_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(LEN + 1);

   if (ACC_W < 2 * N) begin : g_bad_acc_w
      $error("booth_prod_accum: ACC_W must be >= 2*N");
   end
   if (LEN < 1) begin : g_bad_len
      $error("booth_prod_accum: LEN must be >= 1");
   end

   state_e                  state_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] sum;
   logic                    ovf;
   logic                    sticky_q;
   logic [CNT_W-1:0]        cnt_q;

   booth_sat_add #(
      .IN_W  (2 * N),
      .ACC_W (ACC_W)
   ) u_add (
      .prod (bus.prod),
      .acc  (acc_q),
      .sum  (sum),
      .ovf  (ovf)
   );

   assign bus.prod_ready = (state_q == ACCUM);
   assign bus.cnt        = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ACCUM;
         acc_q         <= '0;
         cnt_q         <= '0;
         sticky_q      <= 1'b0;
         bus.acc_out   <= '0;
         bus.acc_valid <= 1'b0;
         bus.out_sat   <= 1'b0;
      end else if (bus.clear) begin
         // Abort: drop the partial block and any pending result; acc_out keeps its value.
         state_q       <= ACCUM;
         acc_q         <= '0;
         cnt_q         <= '0;
         sticky_q      <= 1'b0;
         bus.acc_valid <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (bus.prod_valid) begin
                  if (cnt_q == CNT_W'(LEN - 1)) begin
                     bus.acc_out   <= sum;
                     bus.out_sat   <= sticky_q | ovf;
                     bus.acc_valid <= 1'b1;
                     state_q       <= EMIT;
                     acc_q         <= '0;
                     cnt_q         <= '0;
                     sticky_q      <= 1'b0;
                  end else begin
                     acc_q    <= sum;
                     cnt_q    <= cnt_q + CNT_W'(1);
                     sticky_q <= sticky_q | ovf;
                  end
               end
            end
            EMIT: begin
               if (bus.acc_ready) begin
                  bus.acc_valid <= 1'b0;
                  state_q       <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end
endmodule
